// File: rtl/star_scanner_if.sv
// Memory port and bounding-box result handshake of the star scanner.
interface star_scanner_if #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int PIX_W = 3,
  parameter int A_W   = 15
);
  logic [A_W-1:0]   mem_addr;
  logic [PIX_W-1:0] mem_rdata;
  logic [PIX_W-1:0] mem_wdata;
  logic             mem_wren;
  logic             star_valid;
  logic             star_ready;
  logic [X_W-1:0]   star_left;
  logic [X_W-1:0]   star_right;
  logic [Y_W-1:0]   star_top;
  logic [Y_W-1:0]   star_bottom;

  modport master (
    output mem_addr, mem_wdata, mem_wren,
    output star_valid, star_left, star_right, star_top, star_bottom,
    input  mem_rdata, star_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_wren,
    input  star_valid, star_left, star_right, star_top, star_bottom,
    output mem_rdata, star_ready
  );
endinterface

// File: rtl/star_scanner.sv
// Raster-scans a frame held in single-port RAM, measures the bounding box of each bright blob,
// erases the box from memory and hands it out over a valid/ready handshake.
module star_scanner #(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int WIDTH     = 160,
  parameter int HEIGHT    = 120,
  parameter int PIX_W     = 3,
  parameter int MAX_STARS = 8,
  parameter int A_W       = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [PIX_W-1:0]               threshold,
  star_scanner_if.master                 bus,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(MAX_STARS+1)-1:0] star_count,
  output logic                           truncated
);
  localparam int CNT_W = $clog2(MAX_STARS + 1);
  localparam logic [X_W-1:0]   X_LAST  = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STARS);

  typedef enum logic [3:0] {
    IDLE, SCAN_RD, SCAN_CHK, DOWN_RD, DOWN_CHK, LEFT_RD, LEFT_CHK,
    RIGHT_RD, RIGHT_CHK, CLEAN, EMIT, DONE
  } state_t;

  state_t           state_r, nx_state_s;
  logic [X_W-1:0]   sx_r, px_r, lft_r, rgt_r, nx_sx_s, nx_px_s, nx_lft_s, nx_rgt_s;
  logic [Y_W-1:0]   sy_r, py_r, top_r, bot_r, nx_sy_s, nx_py_s, nx_top_s, nx_bot_s;
  logic [PIX_W-1:0] thr_r, nx_thr_s, wdata_r;
  logic [CNT_W-1:0] cnt_r, nx_cnt_s, cnt_inc_s;
  logic             trunc_r, nx_trunc_s;
  logic [A_W-1:0]   addr_r, nx_addr_s;
  logic             wren_r, valid_r, busy_r, done_r;
  logic             hit_s, go_left_s, go_right_s, go_clean_s, advance_s;
  logic [Y_W:0]     mid_sum_s;
  logic [Y_W-1:0]   mid_s;

  function automatic logic [A_W-1:0] pix_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return A_W'(y) * A_W'(WIDTH) + A_W'(x);
  endfunction

  // Next-state and datapath: per-state decisions, then edge-aware probe/scan sequencing.
  always_comb begin
    nx_state_s = state_r;
    nx_sx_s    = sx_r;
    nx_sy_s    = sy_r;
    nx_px_s    = px_r;
    nx_py_s    = py_r;
    nx_lft_s   = lft_r;
    nx_rgt_s   = rgt_r;
    nx_top_s   = top_r;
    nx_bot_s   = bot_r;
    nx_thr_s   = thr_r;
    nx_cnt_s   = cnt_r;
    nx_trunc_s = trunc_r;
    nx_addr_s  = addr_r;
    hit_s      = (bus.mem_rdata > thr_r);
    cnt_inc_s  = cnt_r + CNT_W'(1);
    go_left_s  = 1'b0;
    go_right_s = 1'b0;
    go_clean_s = 1'b0;
    advance_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          nx_thr_s   = threshold;
          nx_cnt_s   = '0;
          nx_trunc_s = 1'b0;
          nx_sx_s    = '0;
          nx_sy_s    = '0;
          nx_state_s = SCAN_RD;
        end else begin
          nx_state_s = IDLE;
        end
      end
      SCAN_RD: nx_state_s = SCAN_CHK;
      SCAN_CHK: begin
        if (hit_s) begin
          nx_top_s = sy_r;
          nx_bot_s = sy_r;
          nx_lft_s = sx_r;
          nx_rgt_s = sx_r;
          if (sy_r == Y_LAST) begin
            go_left_s = 1'b1;
          end else begin
            nx_px_s    = sx_r;
            nx_py_s    = sy_r + Y_W'(1);
            nx_state_s = DOWN_RD;
          end
        end else begin
          advance_s = 1'b1;
        end
      end
      DOWN_RD: nx_state_s = DOWN_CHK;
      DOWN_CHK: begin
        if (hit_s && py_r != Y_LAST) begin
          nx_bot_s   = py_r;
          nx_py_s    = py_r + Y_W'(1);
          nx_state_s = DOWN_RD;
        end else if (hit_s) begin
          nx_bot_s  = py_r;
          go_left_s = 1'b1;
        end else begin
          go_left_s = 1'b1;
        end
      end
      LEFT_RD: nx_state_s = LEFT_CHK;
      LEFT_CHK: begin
        if (hit_s && px_r != '0) begin
          nx_lft_s   = px_r;
          nx_px_s    = px_r - X_W'(1);
          nx_state_s = LEFT_RD;
        end else if (hit_s) begin
          nx_lft_s   = px_r;
          go_right_s = 1'b1;
        end else begin
          go_right_s = 1'b1;
        end
      end
      RIGHT_RD: nx_state_s = RIGHT_CHK;
      RIGHT_CHK: begin
        if (hit_s && px_r != X_LAST) begin
          nx_rgt_s   = px_r;
          nx_px_s    = px_r + X_W'(1);
          nx_state_s = RIGHT_RD;
        end else if (hit_s) begin
          nx_rgt_s   = px_r;
          go_clean_s = 1'b1;
        end else begin
          go_clean_s = 1'b1;
        end
      end
      CLEAN: begin
        if (px_r == rgt_r && py_r == bot_r) begin
          nx_state_s = EMIT;
        end else if (px_r == rgt_r) begin
          nx_px_s = lft_r;
          nx_py_s = py_r + Y_W'(1);
        end else begin
          nx_px_s = px_r + X_W'(1);
        end
      end
      EMIT: begin
        if (bus.star_ready) begin
          nx_cnt_s = cnt_inc_s;
          if (cnt_inc_s == CNT_MAX) begin
            nx_trunc_s = 1'b1;
            nx_state_s = DONE;
          end else begin
            advance_s = 1'b1;
          end
        end else begin
          nx_state_s = EMIT;
        end
      end
      DONE:    nx_state_s = IDLE;
      default: nx_state_s = IDLE;
    endcase

    mid_sum_s = {1'b0, nx_top_s} + {1'b0, nx_bot_s};
    mid_s     = mid_sum_s[Y_W:1];

    // Probes that would step off the image are skipped rather than issued.
    if (go_left_s && sx_r != '0) begin
      nx_state_s = LEFT_RD;
      nx_px_s    = sx_r - X_W'(1);
      nx_py_s    = mid_s;
    end else if ((go_left_s || go_right_s) && sx_r != X_LAST) begin
      nx_state_s = RIGHT_RD;
      nx_px_s    = sx_r + X_W'(1);
      nx_py_s    = mid_s;
    end else if (go_left_s || go_right_s || go_clean_s) begin
      nx_state_s = CLEAN;
      nx_px_s    = nx_lft_s;
      nx_py_s    = nx_top_s;
    end else if (advance_s && sx_r == X_LAST && sy_r == Y_LAST) begin
      nx_state_s = DONE;
    end else if (advance_s && sx_r == X_LAST) begin
      nx_sx_s    = '0;
      nx_sy_s    = sy_r + Y_W'(1);
      nx_state_s = SCAN_RD;
    end else if (advance_s) begin
      nx_sx_s    = sx_r + X_W'(1);
      nx_state_s = SCAN_RD;
    end else begin
      nx_state_s = nx_state_s;
    end

    case (nx_state_s)
      SCAN_RD:                           nx_addr_s = pix_addr(nx_sx_s, nx_sy_s);
      DOWN_RD, LEFT_RD, RIGHT_RD, CLEAN: nx_addr_s = pix_addr(nx_px_s, nx_py_s);
      default:                           nx_addr_s = addr_r;
    endcase
  end

  // State and registered outputs, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      sx_r    <= '0;
      sy_r    <= '0;
      px_r    <= '0;
      py_r    <= '0;
      lft_r   <= '0;
      rgt_r   <= '0;
      top_r   <= '0;
      bot_r   <= '0;
      thr_r   <= '0;
      cnt_r   <= '0;
      trunc_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      wren_r  <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= nx_state_s;
      sx_r    <= nx_sx_s;
      sy_r    <= nx_sy_s;
      px_r    <= nx_px_s;
      py_r    <= nx_py_s;
      lft_r   <= nx_lft_s;
      rgt_r   <= nx_rgt_s;
      top_r   <= nx_top_s;
      bot_r   <= nx_bot_s;
      thr_r   <= nx_thr_s;
      cnt_r   <= nx_cnt_s;
      trunc_r <= nx_trunc_s;
      addr_r  <= nx_addr_s;
      wdata_r <= '0;
      wren_r  <= (nx_state_s == CLEAN);
      valid_r <= (nx_state_s == EMIT);
      busy_r  <= (nx_state_s != IDLE);
      done_r  <= (nx_state_s == DONE);
    end
  end

  assign bus.mem_addr    = addr_r;
  assign bus.mem_wdata   = wdata_r;
  assign bus.mem_wren    = wren_r;
  assign bus.star_valid  = valid_r;
  assign bus.star_left   = lft_r;
  assign bus.star_right  = rgt_r;
  assign bus.star_top    = top_r;
  assign bus.star_bottom = bot_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign star_count      = cnt_r;
  assign truncated       = trunc_r;
endmodule

// File: tb/tb_star_scanner.sv
// Directed bench: a 16x12 scanner (MAX_STARS=2) for the vector table and corner sequences,
// and a full 160x120 scanner for the full-frame case.
module tb_star_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  star_scanner_if ifs ();
  star_scanner_if ifl ();

  logic       start_s = 1'b0, start_l = 1'b0, ready_s = 1'b1;
  logic [2:0] thr_s = 3'd0, thr_l = 3'd0;
  logic       busy_s, done_s, trunc_s, busy_l, done_l, trunc_l;
  logic [1:0] cnt_s;
  logic [3:0] cnt_l;

  assign ifs.star_ready = ready_s;
  assign ifl.star_ready = 1'b1;

  star_scanner #(.WIDTH(16), .HEIGHT(12), .MAX_STARS(2)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .threshold(thr_s), .bus(ifs.master),
    .busy(busy_s), .done(done_s), .star_count(cnt_s), .truncated(trunc_s));

  star_scanner dut_l (
    .clk(clk), .reset(reset), .start(start_l), .threshold(thr_l), .bus(ifl.master),
    .busy(busy_l), .done(done_l), .star_count(cnt_l), .truncated(trunc_l));

  // Model RAMs: one-cycle read latency, with a bench write port and a bulk clear.
  logic [2:0]  mem_s [0:32767];
  logic [2:0]  mem_l [0:32767];
  logic        clr_s = 1'b0, clr_l = 1'b0, tbw_s = 1'b0, tbw_l = 1'b0;
  logic [14:0] tba_s = '0, tba_l = '0;
  logic [2:0]  tbd_s = '0, tbd_l = '0;
  logic [14:0] max_addr_l = '0;

  always @(posedge clk) begin
    if (clr_s) begin
      for (int i = 0; i < 32768; i++) mem_s[i] <= 3'd0;
    end else if (tbw_s) mem_s[tba_s] <= tbd_s;
    else if (ifs.mem_wren) mem_s[ifs.mem_addr] <= ifs.mem_wdata;
    ifs.mem_rdata <= mem_s[ifs.mem_addr];
  end

  always @(posedge clk) begin
    if (clr_l) begin
      for (int i = 0; i < 32768; i++) mem_l[i] <= 3'd0;
    end else if (tbw_l) mem_l[tba_l] <= tbd_l;
    else if (ifl.mem_wren) mem_l[ifl.mem_addr] <= ifl.mem_wdata;
    ifl.mem_rdata <= mem_l[ifl.mem_addr];
    if (ifl.mem_addr > max_addr_l) max_addr_l <= ifl.mem_addr;
  end

  typedef struct {
    int x0, x1, y0, y1;
    logic [2:0] val, thr;
    int en, el, er, et, eb;
  } vec_t;

  vec_t vecs [8];
  int n_s, cyc_s;
  int bl [4], br [4], bt [4], bb [4];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr(input bit big);
    @(negedge clk);
    if (big) clr_l = 1'b1; else clr_s = 1'b1;
    @(negedge clk);
    clr_l = 1'b0;
    clr_s = 1'b0;
  endtask

  task automatic wr(input bit big, input int x, input int y, input logic [2:0] v);
    @(negedge clk);
    if (big) begin tbw_l = 1'b1; tba_l = 15'(y * 160 + x); tbd_l = v; end
    else begin tbw_s = 1'b1; tba_s = 15'(y * 16 + x); tbd_s = v; end
    @(negedge clk);
    tbw_l = 1'b0;
    tbw_s = 1'b0;
  endtask

  function automatic int nz_s();
    int n = 0;
    for (int i = 0; i < 192; i++) if (mem_s[i] != 3'd0) n++;
    return n;
  endfunction

  function automatic int nz_l();
    int n = 0;
    for (int i = 0; i < 19200; i++) if (mem_l[i] != 3'd0) n++;
    return n;
  endfunction

  // Start a frame on the small scanner and collect transferred boxes until done.
  task automatic run_s(input logic [2:0] t);
    bit seen = 1'b0;
    n_s = 0;
    thr_s = t;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    cyc_s = 1;
    while (!seen && cyc_s < 3000) begin
      if (ifs.star_valid && ready_s) begin
        if (n_s < 4) begin
          bl[n_s] = ifs.star_left; br[n_s] = ifs.star_right;
          bt[n_s] = ifs.star_top;  bb[n_s] = ifs.star_bottom;
        end
        n_s++;
      end
      if (done_s) seen = 1'b1;
      else begin @(negedge clk); cyc_s++; end
    end
    chk("small_done_seen", seen, 1);
  endtask

  initial begin
    int k, nl, cyc_l;
    int ll [4], lr [4], lt [4], lb [4];
    bit stable;

    vecs[0] = '{1, 0, 1, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0};
    vecs[1] = '{3, 3, 4, 4, 3'd2, 3'd2, 0, 0, 0, 0, 0};
    vecs[2] = '{3, 3, 4, 4, 3'd2, 3'd1, 1, 3, 3, 4, 4};
    vecs[3] = '{5, 7, 2, 3, 3'd7, 3'd0, 1, 5, 7, 2, 3};
    vecs[4] = '{15, 15, 11, 11, 3'd1, 3'd0, 1, 15, 15, 11, 11};
    vecs[5] = '{0, 0, 0, 0, 3'd4, 3'd3, 1, 0, 0, 0, 0};
    vecs[6] = '{0, 1, 10, 11, 3'd3, 3'd2, 1, 0, 1, 10, 11};
    vecs[7] = '{13, 15, 0, 2, 3'd6, 3'd5, 1, 13, 15, 0, 2};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_s, 0);
    chk("rst_done", done_s, 0);
    chk("rst_valid", ifs.star_valid, 0);
    chk("rst_wren", ifs.mem_wren, 0);
    chk("rst_trunc", trunc_s, 0);
    chk("rst_count", cnt_s, 0);
    chk("rst_addr", ifs.mem_addr, 0);
    chk("rst_wdata", ifs.mem_wdata, 0);
    chk("rst_box", {ifs.star_left, ifs.star_right, ifs.star_top, ifs.star_bottom}, 0);
    chk("rst_busy_large", busy_l, 0);

    for (int i = 0; i < 8; i++) begin
      clr(1'b0);
      for (int y = vecs[i].y0; y <= vecs[i].y1; y++)
        for (int x = vecs[i].x0; x <= vecs[i].x1; x++) wr(1'b0, x, y, vecs[i].val);
      run_s(vecs[i].thr);
      chk($sformatf("v%0d_stars", i), n_s, vecs[i].en);
      chk($sformatf("v%0d_count", i), cnt_s, vecs[i].en);
      chk($sformatf("v%0d_trunc", i), trunc_s, 0);
      chk($sformatf("v%0d_nonzero", i), nz_s(),
          (vecs[i].en == 1 || vecs[i].val == 3'd0) ? 0 :
          (vecs[i].x1 - vecs[i].x0 + 1) * (vecs[i].y1 - vecs[i].y0 + 1));
      if (vecs[i].en == 1) begin
        chk($sformatf("v%0d_box", i), {bl[0], br[0], bt[0], bb[0]},
            {vecs[i].el, vecs[i].er, vecs[i].et, vecs[i].eb});
      end else begin
        chk($sformatf("v%0d_frame_cycles", i), (cyc_s >= 384 && cyc_s <= 392), 1);
      end
      @(negedge clk);
    end

    // Three isolated stars with a limit of two: the scan stops after the second.
    clr(1'b0);
    wr(1'b0, 1, 1, 3'd3);
    wr(1'b0, 5, 5, 3'd3);
    wr(1'b0, 10, 9, 3'd3);
    run_s(3'd0);
    chk("trunc_stars", n_s, 2);
    chk("trunc_flag", trunc_s, 1);
    chk("trunc_count", cnt_s, 2);
    chk("trunc_box0", {bl[0], br[0], bt[0], bb[0]}, {32'd1, 32'd1, 32'd1, 32'd1});
    chk("trunc_box1", {bl[1], br[1], bt[1], bb[1]}, {32'd5, 32'd5, 32'd5, 32'd5});
    chk("trunc_third_untouched", mem_s[9 * 16 + 10], 3);
    @(negedge clk);

    // Consumer stalls for 20 cycles while a box is offered.
    clr(1'b0);
    wr(1'b0, 7, 6, 3'd5);
    ready_s = 1'b0;
    thr_s = 3'd0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    k = 0;
    while (!ifs.star_valid && k < 1000) begin @(negedge clk); k++; end
    chk("stall_valid_seen", ifs.star_valid, 1);
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!ifs.star_valid || ifs.star_left != 8'd7 || ifs.star_right != 8'd7 ||
          ifs.star_top != 7'd6 || ifs.star_bottom != 7'd6 || cnt_s != 2'd0) stable = 1'b0;
    end
    chk("stall_stable", stable, 1);
    ready_s = 1'b1;
    @(negedge clk);
    chk("stall_count_after", cnt_s, 1);
    chk("stall_valid_drop", ifs.star_valid, 0);
    k = 0;
    while (!done_s && k < 1000) begin @(negedge clk); k++; end
    chk("stall_done", done_s, 1);
    @(negedge clk);

    // Reset lands while the box is being erased.
    clr(1'b0);
    for (int y = 3; y <= 5; y++)
      for (int x = 2; x <= 5; x++) wr(1'b0, x, y, 3'd1);
    thr_s = 3'd0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    k = 0;
    while (!ifs.mem_wren && k < 1000) begin @(negedge clk); k++; end
    chk("clean_reached", ifs.mem_wren, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("clean_reset_wren", ifs.mem_wren, 0);
    chk("clean_reset_busy", busy_s, 0);
    chk("clean_reset_valid", ifs.star_valid, 0);
    reset = 1'b0;
    @(negedge clk);

    // Full 160x120 frame: a 5x3 blob plus a single pixel in the last corner.
    clr(1'b1);
    for (int y = 10; y <= 12; y++)
      for (int x = 40; x <= 44; x++) wr(1'b1, x, y, 3'd5);
    wr(1'b1, 159, 119, 3'd1);
    thr_l = 3'd0;
    start_l = 1'b1;
    @(negedge clk);
    start_l = 1'b0;
    cyc_l = 1;
    nl = 0;
    while (!done_l && cyc_l < 40000) begin
      if (ifl.star_valid) begin
        if (nl < 4) begin
          ll[nl] = ifl.star_left; lr[nl] = ifl.star_right;
          lt[nl] = ifl.star_top;  lb[nl] = ifl.star_bottom;
        end
        nl++;
      end
      @(negedge clk);
      cyc_l++;
    end
    chk("large_done", done_l, 1);
    chk("large_stars", nl, 2);
    chk("large_box0", {ll[0], lr[0], lt[0], lb[0]}, {32'd40, 32'd44, 32'd10, 32'd12});
    chk("large_box1", {ll[1], lr[1], lt[1], lb[1]}, {32'd159, 32'd159, 32'd119, 32'd119});
    chk("large_count", cnt_l, 2);
    chk("large_trunc", trunc_l, 0);
    chk("large_zeroed", nz_l(), 0);
    chk("large_max_addr_ok", (max_addr_l <= 15'd19199), 1);
    chk("large_cycles", (cyc_l >= 38400 && cyc_l <= 38600), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/star_scanner.md
STAR_SCANNER -- requirements
Module: star_scanner

Interface
REQ-001 SHALL have parameter X_W, default 8: column coordinate width.
REQ-002 SHALL have parameter Y_W, default 7: row coordinate width.
REQ-003 SHALL have parameter WIDTH, default 160: image columns; HEIGHT, default 120: image rows.
REQ-004 SHALL have parameter PIX_W, default 3: pixel width; MAX_STARS, default 8: star limit per frame; A_W, default 15: address width.
REQ-005 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-007 SHALL have ports start  in  1: begin frame scan (pulse); threshold  in  PIX_W: pixel counts as star when value > threshold.
REQ-008 SHALL have ports mem_addr  out  A_W; mem_rdata  in  PIX_W; mem_wdata  out  PIX_W; mem_wren  out  1: single-port synchronous RAM, read data valid 1 cycle after address.
REQ-009 SHALL have ports star_valid  out  1; star_ready  in  1; star_left, star_right  out  X_W; star_top, star_bottom  out  Y_W: bounding-box result handshake.
REQ-010 SHALL have ports busy  out  1; done  out  1 (1-cycle pulse); star_count  out  $clog2(MAX_STARS+1); truncated  out  1.

Function
REQ-011 SHALL compute mem_addr = y*WIDTH + x, zero-extended to A_W.
REQ-012 SHALL implement states IDLE, SCAN_RD, SCAN_CHK, DOWN_RD, DOWN_CHK, LEFT_RD, LEFT_CHK, RIGHT_RD, RIGHT_CHK, CLEAN, EMIT, DONE.
REQ-013 SHALL latch threshold and clear star_count/truncated on start in IDLE; start ignored outside IDLE.
REQ-014 SHALL raster-scan (x fastest) from (0,0); each pixel costs 2 cycles (RD drives address, CHK compares mem_rdata).
REQ-015 SHALL, on first pixel > threshold at (sx,sy), set top=sy, then probe (sx,sy+1..) until pixel <= threshold or row HEIGHT-1; bottom = last hit row.
REQ-016 SHALL compute mid = floor((top+bottom)/2) using Y_W+1-bit sum.
REQ-017 SHALL probe row mid leftward from sx-1 and rightward from sx+1, stopping at first pixel <= threshold or at column 0 / WIDTH-1; left/right = last hit column (sx if none).
REQ-018 SHALL in CLEAN write 0 to every pixel of the box, one per cycle, rows top..bottom, columns left..right, mem_wren=1 only in CLEAN.
REQ-019 SHALL in EMIT hold star_valid=1 with stable box outputs until star_valid && star_ready; transfer increments star_count.
REQ-020 SHALL after transfer resume scan at (sx+1,sy), wrapping to (0,sy+1) at x=WIDTH-1; cleaned pixels read as 0.
REQ-021 SHALL after pixel (WIDTH-1,HEIGHT-1) checked go to DONE, pulse done 1 cycle, return to IDLE.
REQ-022 SHALL, when star_count reaches MAX_STARS, set truncated=1 and go to DONE without scanning further.
REQ-023 SHALL hold busy=1 in all states except IDLE; star_count/truncated hold until next accepted start.
REQ-024 SHALL produce one star per connected seed; single-pixel star yields left=right=sx, top=bottom=sy.

Reset
REQ-025 SHALL on reset enter IDLE; busy, done, star_valid, mem_wren, truncated = 0; star_count = 0; mem_addr, mem_wdata = 0; box outputs = 0.
REQ-026 SHALL abort any scan, probe, clean or pending EMIT on reset the next cycle; partially cleaned memory is not restored.

Verification
REQ-027 Empty frame, threshold=0, start -> done after 2*19200 cycles + overhead, star_count=0, no star_valid.
REQ-028 One 5x3 star at columns 40..44, rows 10..12, threshold=0 -> box (40,44,10,12), region zeroed in RAM, star_count=1.
REQ-029 Pixel at (159,119) only -> box (159,159,119,119); probes stop at edges, no address beyond 19199.
REQ-030 MAX_STARS=2, three isolated stars -> two transfers, truncated=1, star_count=2.
REQ-031 star_ready held 0 for 20 cycles during EMIT -> outputs stable, no count change; reset asserted mid-CLEAN -> mem_wren=0 next cycle, IDLE.
REQ-032 Pixel value 2 with threshold=2 -> ignored; threshold=1 -> detected.
